// File: rtl/axil_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axil_pkg : response codes and FSM states for the AXI-lite slave   |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    RESP    = 2'd2
  } state_t;

endpackage : axil_pkg
`default_nettype wire

// File: rtl/axil_reg_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axil_reg_bank : register array, one sync write, one comb read     |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int DATA_WD = 8,
  parameter int REG_NUM = 16,
  parameter int IDX_WD  = $clog2(REG_NUM)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               we,
  input  logic [IDX_WD-1:0]  idx,
  input  logic [DATA_WD-1:0] data,
  input  logic [IDX_WD-1:0]  rd_idx,
  output logic [DATA_WD-1:0] rd_data
);

  logic [DATA_WD-1:0] regs [REG_NUM];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[idx] <= data;
    end
  end

  assign rd_data = regs[rd_idx];

endmodule : axil_reg_bank
`default_nettype wire

// File: rtl/axi_lite_write_slave.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_lite_write_slave : AW/W/B slave committing into a reg bank;   |
// | AXIL_WSLV_DECERR_EN selects DECERR for out-of-range writes.       |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module axi_lite_write_slave
  import axil_pkg::*;
#(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 8,
  parameter int REG_NUM = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [ADDR_WD-1:0]         awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_WD-1:0]         wdata,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [$clog2(REG_NUM)-1:0] rd_idx,
  output logic [DATA_WD-1:0]         rd_data,
  output logic                       wr_pulse,
  output logic [$clog2(REG_NUM)-1:0] wr_idx
);

  localparam int IDX_WD = $clog2(REG_NUM);
  localparam logic [ADDR_WD:0] ADDR_LIMIT = (ADDR_WD+1)'(REG_NUM);

`ifdef AXIL_WSLV_DECERR_EN
  localparam logic [1:0] MISS_RESP = RESP_DECERR;
`else
  localparam logic [1:0] MISS_RESP = RESP_OKAY;
`endif

  state_t             state;
  logic               aw_held;
  logic               w_held;
  logic [ADDR_WD-1:0] addr_q;
  logic [DATA_WD-1:0] data_q;

  logic              aw_hs;
  logic              w_hs;
  logic              aw_next;
  logic              w_next;
  logic              in_range;
  logic              bank_we;
  logic [IDX_WD-1:0] addr_idx;

  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign aw_next  = aw_held || aw_hs;
  assign w_next   = w_held || w_hs;
  assign in_range = {1'b0, addr_q} < ADDR_LIMIT;
  assign addr_idx = addr_q[IDX_WD-1:0];
  assign bank_we  = (state == WRITE) && in_range;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= COLLECT;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      wr_pulse <= 1'b0;
      wr_idx   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          wr_pulse <= 1'b0;
          if (aw_hs) begin
            addr_q  <= awaddr;
            aw_held <= 1'b1;
          end
          if (w_hs) begin
            data_q <= wdata;
            w_held <= 1'b1;
          end
          // Ready outputs are registered, so they track the post-edge held flags.
          if (aw_next && w_next) begin
            state   <= WRITE;
            awready <= 1'b0;
            wready  <= 1'b0;
          end else begin
            awready <= !aw_next;
            wready  <= !w_next;
          end
        end
        WRITE: begin
          wr_pulse <= in_range;
          if (in_range) begin
            wr_idx <= addr_idx;
          end
          bresp   <= in_range ? RESP_OKAY : MISS_RESP;
          bvalid  <= 1'b1;
          aw_held <= 1'b0;
          w_held  <= 1'b0;
          state   <= RESP;
        end
        RESP: begin
          wr_pulse <= 1'b0;
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            state   <= COLLECT;
          end
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

  axil_reg_bank #(
    .DATA_WD (DATA_WD),
    .REG_NUM (REG_NUM),
    .IDX_WD  (IDX_WD)
  ) u_reg_bank (
    .clk     (clk),
    .rstn    (rstn),
    .we      (bank_we),
    .idx     (addr_idx),
    .data    (data_q),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

endmodule : axi_lite_write_slave
`default_nettype wire

// File: tb/tb_axi_lite_write_slave.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi_lite_write_slave : randomized bench with register model    |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module tb_axi_lite_write_slave;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] awaddr;
  logic       awvalid;
  logic       awready;
  logic [7:0] wdata;
  logic       wvalid;
  logic       wready;
  logic [1:0] bresp;
  logic       bvalid;
  logic       bready;
  logic [3:0] rd_idx;
  logic [7:0] rd_data;
  logic       wr_pulse;
  logic [3:0] wr_idx;

  int checks = 0;
  int errors = 0;
  logic [7:0] model [16];

  always #5 clk = ~clk;

  axi_lite_write_slave #(
    .DATA_WD (8),
    .ADDR_WD (8),
    .REG_NUM (16)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .wr_pulse (wr_pulse),
    .wr_idx   (wr_idx)
  );

  function automatic logic [1:0] exp_resp(input logic [7:0] addr);
`ifdef AXIL_WSLV_DECERR_EN
    return (addr < 8'd16) ? 2'b00 : 2'b11;
`else
    return 2'b00;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [7:0] data);
    if (addr < 8'd16) model[addr[3:0]] = data;
  endtask

  task automatic peek(input int idx, output logic [7:0] val);
    rd_idx = 4'(idx);
    #1;
    val = rd_data;
  endtask

  // Drives one transaction with independent AW/W start delays and a B stall.
  task automatic run_write(input logic [7:0] addr, input logic [7:0] data,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output int lat, output logic [1:0] resp,
                           output int pulses, output logic [3:0] pidx,
                           output int order_bad, output int stall_bad,
                           output bit ready_after, output bit timeout);
    int c, last_hs, bv_first, bv_cnt;
    bit aw_done, w_done, got_b, hs_aw, hs_w, hs_b;
    c = 0; last_hs = 0; bv_first = -1; bv_cnt = 0;
    aw_done = 0; w_done = 0; got_b = 0;
    pulses = 0; pidx = '0; order_bad = 0; stall_bad = 0; resp = '0;
    while (!got_b && c < 60) begin
      awaddr  = addr;
      wdata   = data;
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      if (wr_pulse) begin pulses++; pidx = wr_idx; end
      if (bvalid) begin
        if (bv_first < 0) begin bv_first = c; resp = bresp; end
        else if (bresp !== resp) stall_bad++;
        if (awready || wready) stall_bad++;
        bready = (bv_cnt >= b_dly);
        bv_cnt++;
      end else begin
        bready = 1'b0;
      end
      if (w_done && !aw_done && !(awready && !wready)) order_bad++;
      if (aw_done && !w_done && !(wready && !awready)) order_bad++;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_b  = bvalid && bready;
      tick();
      c++;
      if (hs_aw) begin aw_done = 1; last_hs = c - 1; end
      if (hs_w)  begin w_done = 1;  last_hs = c - 1; end
      if (hs_b)  got_b = 1;
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    timeout     = !got_b;
    lat         = bv_first - last_hs;
    ready_after = awready && wready;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    rstn = 1'b0; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    awaddr = 8'h02; wdata = 8'h77; rd_idx = '0;
    repeat (3) tick();
    checks++;
    if ({awready, wready, bvalid, bresp, wr_pulse, wr_idx} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got aw=%b w=%b bv=%b br=%b p=%b idx=%0d want all 0",
               awready, wready, bvalid, bresp, wr_pulse, wr_idx);
    end
    for (int i = 0; i < 16; i++) begin
      model[i] = 8'h00;
      peek(i, v);
      checks++;
      if (v !== 8'h00) begin
        errors++;
        $display("FAIL reset_reg[%0d]: got %0h want 00", i, v);
      end
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    rstn = 1'b1;
    tick();
    checks++;
    if (!(awready === 1'b1 && wready === 1'b1)) begin
      errors++;
      $display("FAIL reset_release_ready: got aw=%b w=%b want 1 1", awready, wready);
    end
  endtask

  task automatic test_same_cycle();
    int lat, pulses, ob, sb; logic [1:0] resp; logic [3:0] pidx; bit ra, to; logic [7:0] v;
    run_write(8'h03, 8'hA5, 0, 0, 0, lat, resp, pulses, pidx, ob, sb, ra, to);
    model_write(8'h03, 8'hA5);
    checks++;
    if (to || lat != 2 || resp !== 2'b00) begin
      errors++;
      $display("FAIL same_cycle_resp: got to=%0d lat=%0d resp=%b want 0 2 00", to, lat, resp);
    end
    checks++;
    if (pulses != 1 || pidx !== 4'd3) begin
      errors++;
      $display("FAIL same_cycle_pulse: got n=%0d idx=%0d want 1 3", pulses, pidx);
    end
    peek(3, v);
    checks++;
    if (v !== 8'hA5) begin errors++; $display("FAIL same_cycle_rd: got %0h want a5", v); end
    checks++;
    if (!ra) begin errors++; $display("FAIL same_cycle_ready_after: got 0 want 1"); end
  endtask

  task automatic test_w_before_aw();
    int lat, pulses, ob, sb; logic [1:0] resp; logic [3:0] pidx; bit ra, to; logic [7:0] v;
    run_write(8'h07, 8'h5A, 4, 0, 0, lat, resp, pulses, pidx, ob, sb, ra, to);
    model_write(8'h07, 8'h5A);
    checks++;
    if (ob != 0) begin errors++; $display("FAIL w_first_ready: got %0d bad cycles want 0", ob); end
    checks++;
    if (to || lat != 2 || pulses != 1 || pidx !== 4'd7) begin
      errors++;
      $display("FAIL w_first_commit: got to=%0d lat=%0d n=%0d idx=%0d want 0 2 1 7",
               to, lat, pulses, pidx);
    end
    peek(7, v);
    checks++;
    if (v !== 8'h5A) begin errors++; $display("FAIL w_first_rd: got %0h want 5a", v); end
  endtask

  task automatic test_out_of_range();
    int lat, pulses, ob, sb; logic [1:0] resp; logic [3:0] pidx; bit ra, to; logic [7:0] v;
    logic [7:0] d;
    d = 8'($urandom);
    run_write(8'h20, d, 0, 0, 0, lat, resp, pulses, pidx, ob, sb, ra, to);
    checks++;
    if (to || resp !== exp_resp(8'h20) || pulses != 0) begin
      errors++;
      $display("FAIL oor_resp: got to=%0d resp=%b n=%0d want 0 %b 0",
               to, resp, pulses, exp_resp(8'h20));
    end
    for (int i = 0; i < 16; i++) begin
      peek(i, v);
      checks++;
      if (v !== model[i]) begin
        errors++;
        $display("FAIL oor_reg[%0d]: got %0h want %0h", i, v, model[i]);
      end
    end
  endtask

  task automatic test_bready_stall();
    int lat, pulses, ob, sb; logic [1:0] resp; logic [3:0] pidx; bit ra, to;
    logic [7:0] a, d;
    a = 8'($urandom_range(0, 15));
    d = 8'($urandom);
    run_write(a, d, 0, 0, 5, lat, resp, pulses, pidx, ob, sb, ra, to);
    model_write(a, d);
    checks++;
    if (to || sb != 0 || resp !== 2'b00) begin
      errors++;
      $display("FAIL stall_stable: got to=%0d bad=%0d resp=%b want 0 0 00", to, sb, resp);
    end
    checks++;
    if (!ra) begin errors++; $display("FAIL stall_ready_after: got 0 want 1"); end
  endtask

  task automatic test_back_to_back();
    int rises[$];
    logic [3:0] idxs[$];
    logic [7:0] d [3];
    logic [7:0] v;
    int acc, c;
    bit hs;
    acc = 0; c = 0;
    for (int i = 0; i < 3; i++) d[i] = 8'($urandom);
    bready = 1'b1;
    while (rises.size() < 3 && c < 40) begin
      if (wr_pulse) idxs.push_back(wr_idx);
      if (bvalid) rises.push_back(c);
      if (acc < 3) begin
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 8'(acc); wdata = d[acc];
      end else begin
        awvalid = 1'b0; wvalid = 1'b0;
      end
      hs = awvalid && awready && wvalid && wready;
      tick();
      c++;
      if (hs) acc++;
    end
    bready = 1'b0;
    for (int i = 0; i < 3; i++) model_write(8'(i), d[i]);
    checks++;
    if (rises.size() != 3 || idxs.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got resp=%0d pulses=%0d want 3 3", rises.size(), idxs.size());
    end else begin
      checks++;
      if (rises[1] - rises[0] != 3 || rises[2] - rises[1] != 3) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d %0d want 3 3",
                 rises[1] - rises[0], rises[2] - rises[1]);
      end
      checks++;
      if (idxs[0] !== 4'd0 || idxs[1] !== 4'd1 || idxs[2] !== 4'd2) begin
        errors++;
        $display("FAIL b2b_idx: got %0d %0d %0d want 0 1 2", idxs[0], idxs[1], idxs[2]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      peek(i, v);
      checks++;
      if (v !== model[i]) begin
        errors++;
        $display("FAIL b2b_reg[%0d]: got %0h want %0h", i, v, model[i]);
      end
    end
  endtask

  task automatic test_random();
    int lat, pulses, ob, sb; logic [1:0] resp; logic [3:0] pidx; bit ra, to;
    logic [7:0] a, d, v;
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(16, 255));
      d = 8'($urandom);
      run_write(a, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), lat, resp, pulses, pidx, ob, sb, ra, to);
      model_write(a, d);
      checks++;
      if (to || lat != 2 || resp !== exp_resp(a) || sb != 0 || ob != 0 || !ra) begin
        errors++;
        $display("FAIL rand_txn addr=%0h: got to=%0d lat=%0d resp=%b sb=%0d ob=%0d ra=%0d want 0 2 %b 0 0 1",
                 a, to, lat, resp, sb, ob, ra, exp_resp(a));
      end
      checks++;
      if ((a < 8'd16) ? (pulses != 1 || pidx !== a[3:0]) : (pulses != 0)) begin
        errors++;
        $display("FAIL rand_pulse addr=%0h: got n=%0d idx=%0d", a, pulses, pidx);
      end
    end
    for (int i = 0; i < 16; i++) begin
      peek(i, v);
      checks++;
      if (v !== model[i]) begin
        errors++;
        $display("FAIL rand_reg[%0d]: got %0h want %0h", i, v, model[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int seen_b;
    awaddr = 8'h04; wdata = 8'hFF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    checks++;
    if (!(awready && wready)) begin
      errors++;
      $display("FAIL rst_mid_ready: got aw=%b w=%b want 1 1", awready, wready);
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    rstn = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) model[i] = 8'h00;
    checks++;
    if ({awready, wready, bvalid, bresp, wr_pulse, wr_idx} !== 10'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got aw=%b w=%b bv=%b br=%b p=%b idx=%0d want all 0",
               awready, wready, bvalid, bresp, wr_pulse, wr_idx);
    end
    peek(4, v);
    checks++;
    if (v !== 8'h00) begin errors++; $display("FAIL rst_mid_reg4: got %0h want 00", v); end
    rstn = 1'b1;
    seen_b = 0;
    repeat (6) begin
      tick();
      if (bvalid || wr_pulse) seen_b++;
    end
    checks++;
    if (seen_b != 0 || !(awready && wready)) begin
      errors++;
      $display("FAIL rst_mid_after: got stray=%0d aw=%b w=%b want 0 1 1", seen_b, awready, wready);
    end
    bready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_out_of_range();
    test_bready_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_axi_lite_write_slave
`default_nettype wire

// File: doc/axi_lite_write_slave.md
# axi_lite_write_slave

AXI-lite write-side slave that terminates the address-write, write-data and write-response channels driven by `axi_lite_write_master` and commits each accepted write into a local register bank. Sits directly downstream of the write master. Exposes an observation read port and a one-cycle commit pulse for neighbouring logic. Every transaction completes with exactly one write response.

## Interface

Parameters:
- `DATA_WD`, 8: width of write data and of each register.
- `ADDR_WD`, 8: width of `awaddr`.
- `REG_NUM`, 16: number of registers in the bank; must be ≤ 2^ADDR_WD.

Ports:
- `clk`  input  1  single clock; all logic on rising edge.
- `rstn`  input  1  reset, synchronous and active-low.
- `awaddr`  input  ADDR_WD  write address.
- `awvalid`  input  1  address valid.
- `awready`  output  1  address accepted.
- `wdata`  input  DATA_WD  write data.
- `wvalid`  input  1  data valid.
- `wready`  output  1  data accepted.
- `bresp`  output  2  write response code.
- `bvalid`  output  1  response valid.
- `bready`  input  1  master accepts response.
- `rd_idx`  input  $clog2(REG_NUM)  observation read index.
- `rd_data`  output  DATA_WD  combinational `regs[rd_idx]`.
- `wr_pulse`  output  1  high for one cycle when a register is updated.
- `wr_idx`  output  $clog2(REG_NUM)  index written, valid with `wr_pulse`.

## Operation

- State machine with three states:
  - COLLECT: idle, gathering address and data.
  - WRITE: commit.
  - RESP: response pending.
- COLLECT:
  - `awready = !aw_held`; `wready = !w_held`.
  - An AW handshake latches `awaddr` and sets `aw_held`.
  - A W handshake latches `wdata` and sets `w_held`.
  - The two channels complete independently in either order, or in the same cycle.
  - When both are held after the current edge, including two same-cycle handshakes, next state is WRITE.
- WRITE:
  - `awready = wready = 0`.
  - Decode the latched address: in range iff `awaddr < REG_NUM`.
  - In range: write `regs[awaddr]`, pulse `wr_pulse`, drive `wr_idx`, and set `bresp = OKAY`.
  - Out of range: no register write, no `wr_pulse`; `bresp` per Configuration.
  - Set `bvalid`, clear `aw_held` and `w_held`, go to RESP.
- RESP:
  - `bvalid = 1` and `bresp` stable until `bready`.
  - On the `bvalid && bready` edge: clear `bvalid`, go to COLLECT.
- No new AW/W is accepted outside COLLECT. Holding `awvalid`/`wvalid` during WRITE or RESP is legal and they are accepted on return.
- Reset values: `awready=0`, `wready=0`, `bvalid=0`, `bresp=2'b00`, `wr_pulse=0`, `wr_idx=0`, all `regs=0`, state COLLECT. `awready`/`wready` rise the first cycle after `rstn` is released.
- Reset mid-operation: the next edge with `rstn=0` discards held address/data and any pending response. No `bvalid` is issued for the discarded transaction.

## Timing

- Last handshake in cycle N → WRITE in cycle N+1 → `bvalid=1`, `wr_pulse=1` and the new `rd_data` visible in cycle N+2.
- `wr_pulse` lasts exactly one cycle; `bvalid` holds until the handshake.
- `bready` already high when `bvalid` rises → handshake in N+2, COLLECT with ready high in N+3.
- Back-to-back throughput: one write per 3 cycles minimum.
- `rd_data` is combinational from the register array; no read latency.

## Configuration

- Macro `AXIL_WSLV_DECERR_EN`:
  - Defined: out-of-range writes respond `bresp = DECERR (2'b11)`.
  - Undefined: out-of-range writes respond `OKAY (2'b00)` and are silently dropped.
- In-range behaviour is identical in both builds.

## Structure

- Shared package `axil_pkg`:
  - Response constants `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`, `RESP_DECERR=2'b11`.
  - State enum `{COLLECT, WRITE, RESP}`.
- Sub-module `axil_reg_bank` holds `regs[REG_NUM]`: one synchronous write port (`we`, `idx`, `data`), one combinational read port, synchronous clear on reset. The slave owns channel handshakes, FSM and decode.

## Test plan

- AW at `0x03` and W `0xA5` in the same cycle, `bready=1` → `bvalid` two cycles later with `bresp=00`, `wr_pulse` with `wr_idx=3`, `rd_data(3)=0xA5`.
- W `0x5A` 4 cycles before AW `0x07` → `wready` drops after W, `awready` stays high; commit only after AW; `regs[7]=0x5A`.
- Write `0x20` (`REG_NUM=16`) → no register change, no `wr_pulse`; `bresp=11` with the macro defined, `00` without.
- `bready` held low 5 cycles → `bvalid`/`bresp` stable, `awready=wready=0` throughout; COLLECT one cycle after `bready` rises.
- Both valids held continuously for 3 writes to indices 0,1,2 → one response per 3 cycles, registers hold the written data.
- `rstn=0` for one cycle in WRITE after `0xFF` was captured for index 4 → no `bvalid`, `regs[4]=0`, all outputs at reset values.
